// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module : mem_stage_pkg
// Brief  : Shared widths, base address, FSM encodings and the MEM/WB payload.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int          WORD_W        = 32;
    localparam int          REG_IDX_W     = 4;
    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_WAIT = 1'b1;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic [REG_IDX_W-1:0] dest;
        logic [WORD_W-1:0]    alu_result;
        logic [WORD_W-1:0]    mem_data;
        logic                 align_err;
    } mem_wb_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_data_memory.sv
// ============================================================================
// Module : data_memory
// Brief  : Word-wide data RAM, synchronous write and combinational read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    // Contents are deliberately not reset.
    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module : mem_stage
// Brief  : Pipeline memory stage with wait-state FSM, freeze and MEM/WB reg.
//          Optional macro MEM_ALIGN_CHECK_EN flags and suppresses misaligned ops.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 wb_en_in,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic [WORD_W-1:0]    alu_result,
    input  logic [WORD_W-1:0]    st_val,
    output logic                 freeze,
    output logic                 out_valid,
    output logic                 wb_en_out,
    output logic                 mem_r_en_out,
    output logic [REG_IDX_W-1:0] dest_out,
    output logic [WORD_W-1:0]    alu_result_out,
    output logic [WORD_W-1:0]    mem_data_out,
    output logic                 align_err
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             CW       = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WAIT_CYCLES);
    localparam logic [WORD_W-1:0] SPAN  = WORD_W'(DEPTH * 4);

    logic [0:0]        r_state;
    logic [0:0]        w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_next_cnt;
    logic              w_freeze;
    logic              w_access;
    logic              w_mem_op;
    logic              w_capture;
    logic              w_misalign;
    logic              w_in_range;
    logic              w_we;
    logic [WORD_W-1:0] w_offset;
    logic [AW-1:0]     w_idx;
    logic [WORD_W-1:0] w_rdata;
    mem_wb_t           r_wb;

    assign w_mem_op   = in_valid & (mem_read | mem_write);
    assign w_offset   = alu_result - BASE_ADDR;
    // Comparing the byte offset against the byte span is equivalent to idx < DEPTH.
    assign w_in_range = (alu_result >= BASE_ADDR) && (w_offset < SPAN);
    assign w_idx      = w_offset[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (alu_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_freeze     = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) begin
                    if (WAIT_CYCLES == 0) begin
                        w_access = 1'b1;
                    end else begin
                        w_freeze     = 1'b1;
                        w_next_state = S_WAIT;
                        w_next_cnt   = CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == CNT_LAST) begin
                    w_access     = 1'b1;
                    w_next_state = S_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_freeze   = 1'b1;
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Gating with rst_n makes an in-flight access abort cleanly while reset is held.
    assign freeze    = w_freeze & rst_n;
    assign w_we      = w_access & mem_write & w_in_range & ~w_misalign & rst_n;
    assign w_capture = w_access | ((r_state == S_IDLE) & in_valid & ~w_mem_op);

    data_memory #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (st_val),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            r_wb      <= '0;
        end else if (w_capture) begin
            out_valid          <= 1'b1;
            r_wb.wb_en         <= wb_en_in;
            r_wb.mem_r_en      <= mem_read & w_mem_op;
            r_wb.dest          <= dest_in;
            r_wb.alu_result    <= alu_result;
            r_wb.mem_data      <= (w_mem_op && mem_read && w_in_range) ? w_rdata : '0;
            r_wb.align_err     <= w_mem_op & w_misalign;
        end else begin
            out_valid <= 1'b0;
        end
    end

    assign wb_en_out      = r_wb.wb_en;
    assign mem_r_en_out   = r_wb.mem_r_en;
    assign dest_out       = r_wb.dest;
    assign alu_result_out = r_wb.alu_result;
    assign mem_data_out   = r_wb.mem_data;
    assign align_err      = r_wb.align_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module : tb_mem_stage
// Brief  : Scoreboard bench for mem_stage with directed load/store vectors.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        wb_en_in;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  dest_in;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic        freeze;
    logic        out_valid;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;
    logic        align_err;

    typedef struct packed {
        logic        wb;
        logic        rd;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] data;
        logic        al;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_ON = 1'b1;
`else
    localparam logic ALIGN_ON = 1'b0;
`endif

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .wb_en_in       (wb_en_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .dest_in        (dest_in),
        .alu_result     (alu_result),
        .st_val         (st_val),
        .freeze         (freeze),
        .out_valid      (out_valid),
        .wb_en_out      (wb_en_out),
        .mem_r_en_out   (mem_r_en_out),
        .dest_out       (dest_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .align_err      (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Monitor: pops one expected payload per out_valid cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 80'(1), 80'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("payload",
                    80'({wb_en_out, mem_r_en_out, dest_out, alu_result_out, mem_data_out, align_err}),
                    80'(e));
            end
        end
    end

    // Called just after a rising edge; returns just after the access edge.
    task automatic do_op(input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
                         input logic [31:0] alu, input logic [31:0] st,
                         input logic [31:0] exp_data, input logic exp_al, input string name);
        int  nf;
        logic done;
        exp_t e;
        in_valid   = 1'b1;
        wb_en_in   = wb;
        mem_read   = rd;
        mem_write  = wr;
        dest_in    = dest;
        alu_result = alu;
        st_val     = st;
        e = '{wb: wb, rd: rd, dest: dest, alu: alu, data: exp_data, al: exp_al};
        exp_q.push_back(e);
        nf   = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (freeze) nf++;
            else done = 1'b1;
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        chk({name, "_timeout"}, 80'(done), 80'(1));
        chk({name, "_freeze_cycles"}, 80'(nf), ((rd | wr) ? 80'(3) : 80'(0)));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        wb_en_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        dest_in    = 4'd0;
        alu_result = 32'd0;
        st_val     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            80'({freeze, out_valid, wb_en_out, mem_r_en_out, dest_out, alu_result_out, mem_data_out, align_err}),
            80'(0));
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 1: plain ALU op
        do_op(1, 0, 0, 4'd3, 32'h55, 32'h0, 32'h0, 1'b0, "alu_op");
        idle(1);
        // 2: store then load at base
        do_op(0, 0, 1, 4'd1, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0, "str_base");
        idle(1);
        do_op(1, 1, 0, 4'd2, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, "ldr_base");
        idle(2);
        // 3: range boundaries
        do_op(0, 0, 1, 4'd0, 32'd1276, 32'h0000A5A5, 32'h0, 1'b0, "str_last");
        do_op(0, 0, 1, 4'd0, 32'd1020, 32'h11111111, 32'h0, 1'b0, "str_below");
        do_op(0, 0, 1, 4'd0, 32'd1280, 32'h22222222, 32'h0, 1'b0, "str_above");
        do_op(1, 1, 0, 4'd4, 32'd1276, 32'h0, 32'h0000A5A5, 1'b0, "ldr_last");
        do_op(1, 1, 0, 4'd5, 32'd1020, 32'h0, 32'h0, 1'b0, "ldr_below");
        do_op(1, 1, 0, 4'd6, 32'd1280, 32'h0, 32'h0, 1'b0, "ldr_above");
        do_op(1, 1, 0, 4'd7, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, "ldr_base_kept");
        idle(1);
        // 4: reset during the second freeze cycle aborts the store
        do_op(0, 0, 1, 4'd5, 32'd1028, 32'hCAFE0001, 32'h0, 1'b0, "str_prev");
        in_valid   = 1'b1;
        mem_write  = 1'b1;
        wb_en_in   = 1'b0;
        dest_in    = 4'd9;
        alu_result = 32'd1028;
        st_val     = 32'h00001234;
        @(negedge clk);
        chk("abort_freeze_c1", 80'(freeze), 80'(1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero",
            80'({freeze, out_valid, wb_en_out, mem_r_en_out, dest_out, alu_result_out, mem_data_out, align_err}),
            80'(0));
        in_valid  = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        do_op(1, 1, 0, 4'd8, 32'd1028, 32'h0, 32'hCAFE0001, 1'b0, "ldr_after_abort");
        idle(1);
        // 5: back-to-back store/load
        do_op(0, 0, 1, 4'd1, 32'd1032, 32'd7, 32'h0, 1'b0, "b2b_str");
        do_op(1, 1, 0, 4'd10, 32'd1032, 32'h0, 32'd7, 1'b0, "b2b_ldr");
        idle(1);
        // 6: misaligned store
        do_op(0, 0, 1, 4'd0, 32'd1026, 32'h0000600D, 32'h0, ALIGN_ON, "str_misaligned");
        do_op(1, 1, 0, 4'd11, 32'd1024, 32'h0,
              (ALIGN_ON ? 32'hDEADBEEF : 32'h0000600D), 1'b0, "ldr_after_misaligned");

        idle(3);
        chk("scoreboard_drained", 80'(exp_q.size()), 80'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
